// File: rtl/alu_wide_seq.sv
// Byte-serial sequencer that runs NBYTES-wide arithmetic/logic ops on a shared 8-bit ALU,
// least significant byte first, with a start/busy/done handshake.
module alu_wide_seq #(
    parameter int unsigned NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    input  logic                  ci_in,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cy_out,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [2:0]            alu_op,
    output logic                  alu_ci,
    input  logic [7:0]            alu_out,
    input  logic                  alu_cy
);

    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic               w_accept;

    logic [2:0]         r_op;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_result;
    logic               r_cy_out;
    logic               r_busy;
    logic               r_done;

    logic [7:0]         w_a_byte;
    logic [7:0]         w_b_byte;
    logic               w_last;
    logic               w_arith;
    logic               w_carry_nxt;

    assign w_a_byte = r_a[{r_idx, 3'b000} +: 8];
    assign w_b_byte = r_b[{r_idx, 3'b000} +: 8];
    assign w_last   = (r_idx == IDX_W'(NBYTES - 1));
    assign w_arith  = (r_op == OP_ADD) || (r_op == OP_SUB);

    // Carry/borrow into the next byte; the ALU gives no borrow, so SUB derives it here.
    always_comb begin
        w_carry_nxt = 1'b0;
        case (r_op)
            OP_ADD:  w_carry_nxt = alu_cy;
            OP_SUB:  w_carry_nxt = ({1'b0, w_a_byte} < ({1'b0, w_b_byte} + 9'(r_carry)));
            default: w_carry_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, per-byte result write-back and carry chaining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_MOV;
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cy_out <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_op     <= op;
                r_a      <= opa;
                r_b      <= opb;
                r_idx    <= '0;
                r_carry  <= ((op == OP_ADD) || (op == OP_SUB)) ? ci_in : 1'b0;
                r_result <= '0;
                r_cy_out <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_result[{r_idx, 3'b000} +: 8] <= alu_out;
                r_carry <= w_carry_nxt;
                if (w_last) begin
                    r_cy_out <= w_carry_nxt;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    // ALU drive is only live in RUN; otherwise it idles at a MOV of zero.
    always_comb begin
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        alu_op = OP_MOV;
        alu_ci = 1'b0;
        if (r_state == S_RUN) begin
            alu_a  = w_a_byte;
            alu_b  = w_b_byte;
            alu_op = r_op;
            alu_ci = w_arith ? r_carry : 1'b0;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign cy_out = r_cy_out;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: directed table, random ops against a full-width model,
// and hand sequences for ignored start, mid-run reset and back-to-back ops.
module tb_alu_wide_seq;

    localparam int unsigned NB = 2;
    localparam int unsigned W  = 8 * NB;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic           ci_in;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           cy_out;
    logic [7:0]     alu_a;
    logic [7:0]     alu_b;
    logic [2:0]     alu_op;
    logic           alu_ci;
    logic [7:0]     alu_out;
    logic           alu_cy;

    int n_vec;
    int n_bad;

    alu_wide_seq #(.NBYTES(NB)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .opa     (opa),
        .opb     (opb),
        .ci_in   (ci_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cy_out  (cy_out),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_ci  (alu_ci),
        .alu_out (alu_out),
        .alu_cy  (alu_cy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared 8-bit ALU: SUB uses alu_ci as borrow-in.
    always_comb begin
        alu_out = 8'h00;
        alu_cy  = 1'b0;
        case (alu_op)
            3'd0:    {alu_cy, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_ci);
            3'd1:    alu_out = alu_a - alu_b - 8'(alu_ci);
            3'd2:    alu_out = alu_a & alu_b;
            3'd3:    alu_out = alu_a | alu_b;
            3'd4:    alu_out = alu_a ^ alu_b;
            3'd5:    alu_out = ~alu_a;
            default: alu_out = alu_b;
        endcase
    end

    // Full-width reference: returns {cy, result}.
    function automatic logic [W:0] ref_op(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic c);
        logic [W:0] t;
        case (o)
            3'd0:    t = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
            3'd1:    t = (W+1)'(a) - (W+1)'(b) - (W+1)'(c);
            3'd2:    t = {1'b0, a & b};
            3'd3:    t = {1'b0, a | b};
            3'd4:    t = {1'b0, a ^ b};
            3'd5:    t = {1'b0, ~a};
            default: t = {1'b0, b};
        endcase
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full transaction with fixed-latency handshake checks; inputs are scrambled after accept.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] er, input logic ecy);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b; ci_in = c;
        @(negedge clk);
        start = 1'b0; op = ~o; opa = ~a; opb = ~b; ci_in = ~c;
        for (int i = 1; i <= int'(NB); i++) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " done_early"}, 32'(done), 32'd0);
            chk({tag, " alu_op"}, 32'(alu_op), 32'(o));
            @(negedge clk);
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, " result"}, 32'(result), 32'(er));
        chk({tag, " cy_out"}, 32'(cy_out), 32'(ecy));
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        chk({tag, " result_hold"}, 32'(result), 32'(er));
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] res;
        logic         cy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [W:0]   m;
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        n_vec = 0;
        n_bad = 0;

        tbl[0] = '{3'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        tbl[1] = '{3'd0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[2] = '{3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
        tbl[3] = '{3'd1, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0};
        tbl[4] = '{3'd1, 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1};
        tbl[5] = '{3'd4, 16'hA5A5, 16'h0FF0, 1'b1, 16'hAA55, 1'b0};
        tbl[6] = '{3'd5, 16'h00F0, 16'h1234, 1'b0, 16'hFF0F, 1'b0};
        tbl[7] = '{3'd6, 16'h5555, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0};
        tbl[8] = '{3'd2, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0};
        tbl[9] = '{3'd7, 16'h1200, 16'h0034, 1'b0, 16'h0034, 1'b0};

        rst = 1'b1; start = 1'b0; op = 3'd0; opa = '0; opb = '0; ci_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", 32'(result), 32'd0);
        chk("rst cy_out", 32'(cy_out), 32'd0);
        chk("rst alu_a", 32'(alu_a), 32'd0);
        chk("rst alu_b", 32'(alu_b), 32'd0);
        chk("rst alu_op", 32'(alu_op), 32'd6);
        chk("rst alu_ci", 32'(alu_ci), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ci,
                   tbl[i].res, tbl[i].cy);
        end

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (i % 6 == 0) rb = ra;
            m = ref_op(ro, ra, rb, rc);
            run_op($sformatf("rnd%0d", i), ro, ra, rb, rc, m[W-1:0], m[W]);
        end

        // Start pulsed mid-run with different operands must be ignored.
        @(negedge clk);
        start = 1'b1; op = 3'd0; opa = 16'h11F0; opb = 16'h2220; ci_in = 1'b1;
        @(negedge clk);
        start = 1'b1; op = 3'd1; opa = 16'h9999; opb = 16'h7777; ci_in = 1'b0;
        chk("ign busy1", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("ign busy2", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ign done", 32'(done), 32'd1);
        chk("ign result", 32'(result), 32'h3411);
        chk("ign cy_out", 32'(cy_out), 32'd0);
        @(negedge clk);
        chk("ign no_rerun", 32'(busy), 32'd0);

        // Reset during RUN aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; op = 3'd0; opa = 16'h0101; opb = 16'h0202; ci_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("abort busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy_clr", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        chk("abort alu_op", 32'(alu_op), 32'd6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort no_done", 32'(done), 32'd0);
            chk("abort idle", 32'(busy), 32'd0);
        end

        // Start held high across DONE: second op accepted, fresh carry-in.
        @(negedge clk);
        start = 1'b1; op = 3'd0; opa = 16'hFFFF; opb = 16'h0001; ci_in = 1'b0;
        @(negedge clk);
        opa = 16'h0001; opb = 16'h0001; ci_in = 1'b0;
        chk("b2b busy1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b busy2", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b done1", 32'(done), 32'd1);
        chk("b2b result1", 32'(result), 32'h0000);
        chk("b2b cy1", 32'(cy_out), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b busy3", 32'(busy), 32'd1);
        chk("b2b done_low", 32'(done), 32'd0);
        @(negedge clk);
        chk("b2b busy4", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b done2", 32'(done), 32'd1);
        chk("b2b result2", 32'(result), 32'h0002);
        chk("b2b cy2", 32'(cy_out), 32'd0);
        @(negedge clk);
        chk("b2b end", 32'(done | busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
